// File: rtl/bdi_multiport_frontend.sv
// rtl/bdi_multiport_frontend.sv - multi-port round-robin request front-end for the BDI compressed cache
//
// Purpose:
//   Arbitrates NUM_PORTS requesters round-robin onto the single request
//   channel of the cache subsystem. Keeps exactly one request outstanding and
//   returns the response to its owner as a one-cycle hit-qualified pulse.
//
// Optional feature macro: PERF_COUNTERS_EN
//   Defined     -> saturating hit/miss counters on perf_hits / perf_misses.
//   Not defined -> perf_hits and perf_misses are tied to 0.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   port_req_*      per-port request: valid/ready handshake, addr, op (1=rd), wdata
//   port_rsp_*      per-port response pulse, shared hit flag and read data
//   sys_req_*       latched request towards the cache subsystem (valid/ready)
//   sys_rsp_*       response strobe, hit flag and read data from the subsystem
//   perf_hits/misses  response counters
module bdi_multiport_frontend #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          port_req_valid,
  output logic [NUM_PORTS-1:0]          port_req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_req_addr,
  input  logic [NUM_PORTS-1:0]          port_req_op_rd,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_req_wdata,
  output logic [NUM_PORTS-1:0]          port_rsp_valid,
  output logic                          port_rsp_hit,
  output logic [DATA_W-1:0]             port_rsp_rdata,
  output logic                          sys_req_valid,
  input  logic                          sys_req_ready,
  output logic [ADDR_W-1:0]             sys_req_addr,
  output logic                          sys_req_op_rd,
  output logic [DATA_W-1:0]             sys_req_wdata,
  input  logic                          sys_rsp_valid,
  input  logic                          sys_rsp_hit,
  input  logic [DATA_W-1:0]             sys_rsp_rdata,
  output logic [CNT_W-1:0]              perf_hits,
  output logic [CNT_W-1:0]              perf_misses
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 op_q, op_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;

  // Round-robin search starting one past the last granted port, so the most
  // recent winner has the lowest priority on the next arbitration.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (!grant_found && port_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    port_req_ready = '0;
    if (state_q == ST_IDLE && grant_found) begin
      port_req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    // Response registers default to zero so the pulse lasts exactly one cycle
    // and hit/rdata read as 0 outside it.
    rsp_valid_d = '0;
    rsp_hit_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          ptr_d   = grant_idx;
          owner_d = grant_idx;
          addr_d  = port_req_addr[grant_idx*ADDR_W +: ADDR_W];
          op_d    = port_req_op_rd[grant_idx];
          wdata_d = port_req_wdata[grant_idx*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sys_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sys_rsp_valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_hit_d            = sys_rsp_hit;
          rsp_rdata_d          = op_q ? sys_rsp_rdata : '0;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_W'(NUM_PORTS - 1);
      owner_q     <= '0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign sys_req_valid  = (state_q == ST_ISSUE);
  assign sys_req_addr   = addr_q;
  assign sys_req_op_rd  = op_q;
  assign sys_req_wdata  = wdata_q;
  assign port_rsp_valid = rsp_valid_q;
  assign port_rsp_hit   = rsp_hit_q;
  assign port_rsp_rdata = rsp_rdata_q;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] hits_q;
  logic [CNT_W-1:0] misses_q;
  logic             take_rsp;

  // Only responses accepted in WAIT are counted; strays are ignored.
  assign take_rsp = (state_q == ST_WAIT) && sys_rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (take_rsp) begin
      if (sys_rsp_hit) begin
        if (hits_q != '1) hits_q <= hits_q + 1'b1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 1'b1;
      end
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule
